// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the pipeline hazard controller and forwarding unit
package pipe_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {RUN, STALL} hz_state_t;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: ALU operand forwarding selects; EX_MEM result beats MEM_WB, $0 never forwarded
module fwd_unit
  import pipe_pkg::*;
(
  input  logic       mem_rw,
  input  logic [4:0] mem_wreg,
  input  logic       wb_rw,
  input  logic [4:0] wb_wreg,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  logic mem_ok, wb_ok;
  always_comb begin
    mem_ok = mem_rw && mem_wreg != REG_ZERO;
    wb_ok = wb_rw && wb_wreg != REG_ZERO;
    fwd_a = (mem_ok && mem_wreg == ex_rs) ? FWD_MEM : (wb_ok && wb_wreg == ex_rs) ? FWD_WB : FWD_REG;
    fwd_b = (mem_ok && mem_wreg == ex_rt) ? FWD_MEM : (wb_ok && wb_wreg == ex_rt) ? FWD_WB : FWD_REG;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and forwarding control for a 5-stage pipeline
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rt,
  input  logic             ex_mread,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             mem_rw,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_branch,
  input  logic             mem_zf,
  input  logic             wb_rw,
  input  logic [4:0]       wb_wreg,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_t state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [1:0] raw_a, raw_b;
  logic lu, br, stall_inc, flush_inc;
  fwd_unit u_fwd (
    .mem_rw(mem_rw), .mem_wreg(mem_wreg), .wb_rw(wb_rw), .wb_wreg(wb_wreg),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(raw_a), .fwd_b(raw_b)
  );
  always_comb begin
    lu = ex_mread && ex_rt != REG_ZERO && (ex_rt == id_rs || (id_use_rt && ex_rt == id_rt));
    br = mem_branch && mem_zf;
    state_d = state_q;
    rem_d = rem_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    pc_we = 1'b1;
    ifid_we = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_flush = 1'b0;
    pc_src = 1'b0;
    if (RST) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_flush = 1'b1;
    end else if (br) begin
      pc_src = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_flush = 1'b1;
      state_d = RUN;
      rem_d = '0;
      flush_inc = 1'b1;
    end else if (state_q == STALL || lu) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_flush = 1'b1;
      if (state_q == STALL) begin
        rem_d = rem_q - 3'd1;
        state_d = rem_q == 3'd1 ? RUN : STALL;
      end else begin
        stall_inc = 1'b1;
        state_d = LOAD_STALL_CYC > 1 ? STALL : RUN;
        rem_d = LOAD_STALL_CYC > 1 ? 3'(LOAD_STALL_CYC - 1) : 3'd0;
      end
    end
    fwd_a = RST ? FWD_REG : raw_a;
    fwd_b = RST ? FWD_REG : raw_b;
    stall_cnt_d = (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      rem_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with default, 3-cycle-stall and 4-bit-counter builds
module tb_hazard_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_wreg, wb_wreg;
  logic id_use_rt, ex_mread, mem_rw, mem_branch, mem_zf, wb_rw;
  logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc_we3, ifid_we3, ifid_flush3, idex_flush3, exmem_flush3, pc_src3;
  logic [1:0] fwd_a3, fwd_b3;
  logic [15:0] stall_cnt3, flush_cnt3;
  logic pc_wes, ifid_wes, ifid_flushs, idex_flushs, exmem_flushs, pc_srcs;
  logic [1:0] fwd_as, fwd_bs;
  logic [3:0] stall_cnts, flush_cnts;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl u0 (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_mread(ex_mread), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_rw(mem_rw), .mem_wreg(mem_wreg),
    .mem_branch(mem_branch), .mem_zf(mem_zf), .wb_rw(wb_rw), .wb_wreg(wb_wreg),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  hazard_ctrl #(.LOAD_STALL_CYC(3)) u3 (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_mread(ex_mread), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_rw(mem_rw), .mem_wreg(mem_wreg),
    .mem_branch(mem_branch), .mem_zf(mem_zf), .wb_rw(wb_rw), .wb_wreg(wb_wreg),
    .pc_we(pc_we3), .ifid_we(ifid_we3), .ifid_flush(ifid_flush3), .idex_flush(idex_flush3),
    .exmem_flush(exmem_flush3), .pc_src(pc_src3), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );
  hazard_ctrl #(.CNT_W(4)) us (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_mread(ex_mread), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_rw(mem_rw), .mem_wreg(mem_wreg),
    .mem_branch(mem_branch), .mem_zf(mem_zf), .wb_rw(wb_rw), .wb_wreg(wb_wreg),
    .pc_we(pc_wes), .ifid_we(ifid_wes), .ifid_flush(ifid_flushs), .idex_flush(idex_flushs),
    .exmem_flush(exmem_flushs), .pc_src(pc_srcs), .fwd_a(fwd_as), .fwd_b(fwd_bs),
    .stall_cnt(stall_cnts), .flush_cnt(flush_cnts)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    {id_rs, id_rt, ex_rs, ex_rt, mem_wreg, wb_wreg} = '0;
    {id_use_rt, ex_mread, mem_rw, mem_branch, mem_zf, wb_rw} = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clr();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic set_lu();
    ex_mread = 1'b1;
    ex_rt = 5'd2;
    id_rs = 5'd2;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clr();
    mem_rw = 1'b1; mem_wreg = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
    tick();
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src} !== 6'b001110) begin
      errors++; $display("FAIL reset_ctrl got %b exp 001110", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src});
    end
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got %b exp 0000", {fwd_a, fwd_b});
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %h exp 0", {stall_cnt, flush_cnt});
    end
    RST = 1'b0;
    clr();
    #1;
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src} !== 6'b110000) begin
      errors++; $display("FAIL run_idle got %b exp 110000", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #1;
    checks++;
    if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b00010) begin
      errors++; $display("FAIL lu_stall got %b exp 00010", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush});
    end
    tick();
    clr();
    #1;
    checks++;
    if ({pc_we, ifid_we, idex_flush} !== 3'b110) begin
      errors++; $display("FAIL lu_resume got %b exp 110", {pc_we, ifid_we, idex_flush});
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt);
    end
    ex_mread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
    #1;
    checks++;
    if (pc_we !== 1'b1) begin
      errors++; $display("FAIL lu_rt_unused got %b exp 1", pc_we);
    end
    id_use_rt = 1'b1;
    #1;
    checks++;
    if (pc_we !== 1'b0) begin
      errors++; $display("FAIL lu_rt_used got %b exp 0", pc_we);
    end
    tick();
    clr();
    #1;
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++; $display("FAIL lu_cnt2 got %0d exp 2", stall_cnt);
    end
  endtask

  task automatic test_forward();
    do_reset();
    mem_rw = 1'b1; mem_wreg = 5'd5; wb_rw = 1'b1; wb_wreg = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      errors++; $display("FAIL fwd_prio got %b exp 1010", {fwd_a, fwd_b});
    end
    mem_wreg = 5'd0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      errors++; $display("FAIL fwd_wb got %b exp 0101", {fwd_a, fwd_b});
    end
    mem_wreg = 5'd5; mem_rw = 1'b0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0101) begin
      errors++; $display("FAIL fwd_mem_norw got %b exp 0101", {fwd_a, fwd_b});
    end
    mem_rw = 1'b1; ex_rt = 5'd6; wb_wreg = 5'd6;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1001) begin
      errors++; $display("FAIL fwd_split got %b exp 1001", {fwd_a, fwd_b});
    end
    wb_rw = 1'b0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      errors++; $display("FAIL fwd_wb_norw got %b exp 1000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    ex_mread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rt = 1'b1;
    mem_rw = 1'b1; mem_wreg = 5'd0; wb_rw = 1'b1; wb_wreg = 5'd0; ex_rs = 5'd0;
    #1;
    checks++;
    if ({pc_we, idex_flush, fwd_a, fwd_b} !== 6'b100000) begin
      errors++; $display("FAIL zero_reg got %b exp 100000", {pc_we, idex_flush, fwd_a, fwd_b});
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL zero_cnt got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_lu();
    mem_branch = 1'b1; mem_zf = 1'b1;
    #1;
    checks++;
    if ({pc_src, pc_we, ifid_flush, idex_flush, exmem_flush} !== 5'b11111) begin
      errors++; $display("FAIL br_ctrl got %b exp 11111", {pc_src, pc_we, ifid_flush, idex_flush, exmem_flush});
    end
    tick();
    clr();
    mem_branch = 1'b1;
    #1;
    checks++;
    if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0}) begin
      errors++; $display("FAIL br_cnt got flush %0d stall %0d exp 1 0", flush_cnt, stall_cnt);
    end
    checks++;
    if ({pc_src, exmem_flush, pc_we} !== 3'b001) begin
      errors++; $display("FAIL br_not_taken got %b exp 001", {pc_src, exmem_flush, pc_we});
    end
  endtask

  task automatic test_multi_stall();
    int lo = 0;
    do_reset();
    set_lu();
    #1;
    if (pc_we3 === 1'b0) lo++;
    tick();
    clr();
    for (int i = 0; i < 4; i++) begin
      if (pc_we3 === 1'b0) lo++;
      tick();
    end
    checks++;
    if (lo !== 3) begin
      errors++; $display("FAIL stall3_len got %0d exp 3", lo);
    end
    checks++;
    if (stall_cnt3 !== 16'd1) begin
      errors++; $display("FAIL stall3_cnt got %0d exp 1", stall_cnt3);
    end
    do_reset();
    set_lu();
    tick();
    clr();
    mem_branch = 1'b1; mem_zf = 1'b1;
    #1;
    checks++;
    if ({pc_src3, pc_we3, exmem_flush3} !== 3'b111) begin
      errors++; $display("FAIL stall3_br got %b exp 111", {pc_src3, pc_we3, exmem_flush3});
    end
    tick();
    clr();
    #1;
    checks++;
    if ({pc_we3, flush_cnt3} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL stall3_br_run got pc_we %b flush %0d exp 1 1", pc_we3, flush_cnt3);
    end
    set_lu();
    tick();
    clr();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if ({pc_we3, stall_cnt3, flush_cnt3} !== {1'b1, 16'd0, 16'd0}) begin
      errors++; $display("FAIL stall3_rst got pc_we %b stall %0d flush %0d exp 1 0 0", pc_we3, stall_cnt3, flush_cnt3);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_lu();
    for (int i = 0; i < 20; i++) tick();
    clr();
    #1;
    checks++;
    if (stall_cnts !== 4'd15) begin
      errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnts);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_load_use();
    test_forward();
    test_reg_zero();
    test_branch();
    test_multi_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage IF/ID/EX/MEM/WB datapath.
- Detects load-use hazards and inserts bubbles by stalling PC and IF_ID and zeroing ID_EX control.
- Resolves taken branches in MEM by flushing younger instructions and generates ALU operand forwarding selects.
- Sits beside the datapath; drives register enables/clears and the forwarding muxes in EX. Keeps saturating stall/flush event counters for debug.

Parameters:
- LOAD_STALL_CYC, 1, bubble cycles per load-use hazard (1..7); >1 supports slow DMem.
- CNT_W, 16, width of stall and flush event counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- id_rs  in  5  Ins[25:21] in IF_ID.
- id_rt  in  5  Ins[20:16] in IF_ID.
- id_use_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_mread  in  1  MRead of instruction in ID_EX.
- ex_rs  in  5  rs field held in ID_EX.
- ex_rt  in  5  rt field held in ID_EX.
- mem_rw  in  1  Rw of instruction in EX_MEM.
- mem_wreg  in  5  destination register in EX_MEM.
- mem_branch  in  1  Branch control bit in EX_MEM.
- mem_zf  in  1  ZF latched in EX_MEM.
- wb_rw  in  1  Rw of instruction in MEM_WB.
- wb_wreg  in  5  destination register in MEM_WB.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF_ID write enable.
- ifid_flush  out  1  clear IF_ID at next edge.
- idex_flush  out  1  zero ID_EX WB/M/EX control at next edge.
- exmem_flush  out  1  zero EX_MEM WB/M control at next edge.
- pc_src  out  1  1 = PC loads branch target.
- fwd_a  out  2  ALU operand A select.
- fwd_b  out  2  ALU operand B select (before ALUsrc mux).
- stall_cnt  out  CNT_W  load-use hazard events.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Control outputs are combinational from state and inputs (act same cycle). FSM and counters are registered.
- RST=1:
  - state<=RUN, rem<=0, counters<=0.
  - Outputs forced: pc_we=0, ifid_we=0, all flushes=1, pc_src=0, fwd_a=fwd_b=00.
- Definitions:
  - lu = ex_mread & ex_rt!=0 & (ex_rt==id_rs | (id_use_rt & ex_rt==id_rt)).
  - br = mem_branch & mem_zf.
- FSM:
  - RUN, no br, lu=1: pc_we=0, ifid_we=0, idex_flush=1. stall_cnt++. If LOAD_STALL_CYC>1: state<=STALL, rem<=LOAD_STALL_CYC-1.
  - RUN, no br, lu=0: pc_we=1, ifid_we=1, no flushes.
  - STALL: pc_we=0, ifid_we=0, idex_flush=1, rem<=rem-1. Return to RUN when rem==1. lu is ignored (not recounted).
- Branch priority: br=1 in any state overrides stall.
  - pc_src=1, pc_we=1, ifid_flush=idex_flush=exmem_flush=1.
  - state<=RUN, rem<=0, flush_cnt++.
  - stall_cnt not incremented even if lu=1 that cycle.
- Forwarding (independent of FSM), for operand A using ex_rs (B identical using ex_rt):
  - 10 if mem_rw & mem_wreg!=0 & mem_wreg==ex_rs.
  - else 01 if wb_rw & wb_wreg!=0 & wb_wreg==ex_rs.
  - else 00.
  - EX_MEM wins when both match. Register 0 never forwarded.
- Counters saturate at all-ones; no wrap.
- RST asserted mid-STALL: next cycle RUN, rem=0, counters 0.
- Register file write-before-read is assumed handled by BankR; no WB-to-ID forwarding here.

Decomposition:
- Shared package (pipe_pkg): FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; hz_state_t {RUN, STALL}; REG_ZERO=5'd0.
- One sub-module: fwd_unit (pure combinational forwarding compare), instantiated once; FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: lw $2 in EX (ex_mread=1, ex_rt=2), ID add rs=2 -> pc_we=0, ifid_we=0, idex_flush=1 for 1 cycle, then pc_we=1; stall_cnt=1.
- Forward priority: mem_rw=1, mem_wreg=5, wb_rw=1, wb_wreg=5, ex_rs=5, ex_rt=5 -> fwd_a=10, fwd_b=10; set mem_wreg=0 -> fwd_a=fwd_b=01.
- Register zero: ex_mread=1, ex_rt=0, id_rs=0; mem_wreg=0, ex_rs=0 -> no stall, fwd_a=00, stall_cnt unchanged.
- Branch over stall: lu=1 and mem_branch=1, mem_zf=1 same cycle -> pc_src=1, pc_we=1, all three flushes=1; flush_cnt=1, stall_cnt=0.
- LOAD_STALL_CYC=3: single lu event -> pc_we=0 for exactly 3 cycles; br on 2nd stall cycle -> immediate RUN, pc_src=1; RST in STALL -> counters 0, state RUN.
- Saturation with CNT_W=4: 20 lu events -> stall_cnt holds 15.
